mips_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with a Moore FSM plus a few ready-qualified strobes. It steps each instruction through fetch/decode/execute/memory/writeback, drives all datapath mux selects, the ALU op class and the PC/IR/register/memory strobes, and handshakes with a shared instruction/data memory. It sits between the instruction register (opcode source) and the datapath.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/mips_mem_wait_timer.sv | 32 +++
 rtl/mips_multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// ALU op classes and datapath mux select values.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ERROR     = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory request open and are subject to the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags when the
// count has reached the allowed maximum.
module mips_mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(MEM_WAIT_MAX);

  logic [WAIT_W-1:0] cnt;

  // Clear wins over counting so a fresh access always starts from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_count_en) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign o_expired = (cnt == CNT_MAX);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath. Mux selects follow the
// state alone; IR/PC loads in FETCH and the store completion pulse are
// qualified by the memory ready in the same cycle.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_op_code,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_i_or_d,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic [1:0] o_pc_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op_code,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_instr_done,
  output logic       o_illegal,
  output logic       o_error,
  output logic [3:0] o_state
);

  state_t state;
  state_t state_nxt;
  logic   wait_expired;
  logic   wait_clear;
  logic   wait_count_en;
  logic   op_legal;

  assign op_legal = (i_op_code == OP_RTYPE) || (i_op_code == OP_LW) ||
                    (i_op_code == OP_SW)    || (i_op_code == OP_BEQ) ||
                    (i_op_code == OP_J);

  // Restart the timer whenever a memory-wait state is newly entered.
  assign wait_clear    = is_wait_state(state_nxt) && (state_nxt != state);
  assign wait_count_en = is_wait_state(state) && !i_mem_ready;

  mips_mem_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .WAIT_W       (WAIT_W)
  ) u_wait_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (wait_clear),
    .i_count_en (wait_count_en),
    .o_expired  (wait_expired)
  );

  // Next-state selection; a ready in the expiry cycle still completes normally.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (i_mem_ready)       state_nxt = S_DECODE;
        else if (wait_expired) state_nxt = S_ERROR;
      end
      S_DECODE: begin
        case (i_op_code)
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_nxt = (i_op_code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (i_mem_ready)       state_nxt = S_MEM_WB;
        else if (wait_expired) state_nxt = S_ERROR;
      end
      S_MEM_WRITE: begin
        if (i_mem_ready)       state_nxt = S_FETCH;
        else if (wait_expired) state_nxt = S_ERROR;
      end
      S_EXECUTE:   state_nxt = S_ALU_WB;
      S_ERROR:     state_nxt = S_ERROR;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // State register; ERROR is only left through reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    o_mem_req       = 1'b0;
    o_mem_write     = 1'b0;
    o_i_or_d        = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_pc_src        = PCSRC_ALU;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_REG;
    o_alu_op_code   = ALU_ADD;
    o_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_instr_done    = 1'b0;
    o_illegal       = 1'b0;
    o_error         = 1'b0;
    if (i_rst_n) begin
      case (state)
        S_FETCH: begin
          o_mem_req   = 1'b1;
          o_alu_src_b = SRCB_FOUR;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        S_DECODE: begin
          o_alu_src_b  = SRCB_IMM_SH2;
          o_illegal    = !op_legal;
          o_instr_done = !op_legal;
        end
        S_MEM_ADDR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          o_mem_req = 1'b1;
          o_i_or_d  = 1'b1;
        end
        S_MEM_WB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
          o_instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          o_mem_req    = 1'b1;
          o_mem_write  = 1'b1;
          o_i_or_d     = 1'b1;
          o_instr_done = i_mem_ready;
        end
        S_EXECUTE: begin
          o_alu_src_a   = 1'b1;
          o_alu_op_code = ALU_FUNCT;
        end
        S_ALU_WB: begin
          o_reg_write  = 1'b1;
          o_reg_dst    = 1'b1;
          o_instr_done = 1'b1;
        end
        S_BRANCH: begin
          o_alu_src_a     = 1'b1;
          o_alu_op_code   = ALU_SUB;
          o_pc_write_cond = 1'b1;
          o_pc_src        = PCSRC_ALUOUT;
          o_instr_done    = 1'b1;
        end
        S_JUMP: begin
          o_pc_write   = 1'b1;
          o_pc_src     = PCSRC_JUMP;
          o_instr_done = 1'b1;
        end
        S_ERROR: o_error = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for the multi-cycle MIPS controller: each instruction is expanded into
// the per-cycle trace it should produce, then replayed against the DUT.
module tb_mips_multicycle_ctrl;

  localparam int F = 0, DEC = 1, MADDR = 2, MRD = 3, MWB = 4, MWR = 5;
  localparam int EXE = 6, AWB = 7, BR = 8, JMP = 9, ERR = 10;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [5:0] i_op_code = 6'd0;
  logic       i_mem_ready = 1'b0;
  logic       o_mem_req, o_mem_write, o_i_or_d, o_ir_write, o_pc_write;
  logic       o_pc_write_cond, o_alu_src_a, o_reg_write, o_reg_dst;
  logic       o_mem_to_reg, o_instr_done, o_illegal, o_error;
  logic [1:0] o_pc_src, o_alu_src_b, o_alu_op_code;
  logic [3:0] o_state;
  logic [18:0] vec;
  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(15), .WAIT_W(8)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_op_code(i_op_code),
    .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req),
    .o_mem_write(o_mem_write), .o_i_or_d(o_i_or_d), .o_ir_write(o_ir_write),
    .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond),
    .o_pc_src(o_pc_src), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_alu_op_code(o_alu_op_code),
    .o_reg_write(o_reg_write), .o_reg_dst(o_reg_dst),
    .o_mem_to_reg(o_mem_to_reg), .o_instr_done(o_instr_done),
    .o_illegal(o_illegal), .o_error(o_error), .o_state(o_state)
  );

  always #5 clk = ~clk;

  assign vec = {o_mem_req, o_mem_write, o_i_or_d, o_ir_write, o_pc_write,
                o_pc_write_cond, o_pc_src, o_alu_src_a, o_alu_src_b,
                o_alu_op_code, o_reg_write, o_reg_dst, o_mem_to_reg,
                o_instr_done, o_illegal, o_error};

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010;
  endfunction

  // Expected output word for one cycle, straight from the per-state table.
  function automatic logic [18:0] ev(input int st, input bit rdy, input logic [5:0] op);
    logic mr, mw, iod, irw, pcw, pwc, sa, rw, rd, m2r, done, ill, err;
    logic [1:0] ps, sb, ao;
    {mr, mw, iod, irw, pcw, pwc, sa, rw, rd, m2r, done, ill, err} = '0;
    ps = 2'b00; sb = 2'b00; ao = 2'b00;
    case (st)
      F:     begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      DEC:   begin sb = 2'b11; ill = !legal(op); done = !legal(op); end
      MADDR: begin sa = 1; sb = 2'b10; end
      MRD:   begin mr = 1; iod = 1; end
      MWB:   begin rw = 1; m2r = 1; done = 1; end
      MWR:   begin mr = 1; mw = 1; iod = 1; done = rdy; end
      EXE:   begin sa = 1; ao = 2'b10; end
      AWB:   begin rw = 1; rd = 1; done = 1; end
      BR:    begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; done = 1; end
      JMP:   begin pcw = 1; ps = 2'b10; done = 1; end
      ERR:   err = 1;
      default: ;
    endcase
    return {mr, mw, iod, irw, pcw, pwc, ps, sa, sb, ao, rw, rd, m2r, done, ill, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check state and outputs, then advance a clock.
  task automatic step(input logic [5:0] op, input bit rdy, input int st);
    i_op_code = op;
    i_mem_ready = rdy;
    #1;
    chk($sformatf("state@%0d", st), 32'(o_state), 32'(st));
    chk($sformatf("outs@%0d", st), 32'(vec), 32'(ev(st, rdy, op)));
    @(posedge clk); #1;
  endtask

  // Build the expected state trace of one instruction, then replay it.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int sq[$];
    bit rq[$];
    for (int i = 0; i < fw; i++) begin sq.push_back(F); rq.push_back(1'b0); end
    sq.push_back(F);   rq.push_back(1'b1);
    sq.push_back(DEC); rq.push_back(1'($urandom_range(0, 1)));
    if (op == 6'b000000) begin
      sq.push_back(EXE); rq.push_back(1'($urandom_range(0, 1)));
      sq.push_back(AWB); rq.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'b100011 || op == 6'b101011) begin
      int ms;
      ms = (op == 6'b100011) ? MRD : MWR;
      sq.push_back(MADDR); rq.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < mw; i++) begin sq.push_back(ms); rq.push_back(1'b0); end
      sq.push_back(ms); rq.push_back(1'b1);
      if (op == 6'b100011) begin sq.push_back(MWB); rq.push_back(1'($urandom_range(0, 1))); end
    end else if (op == 6'b000100) begin
      sq.push_back(BR); rq.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'b000010) begin
      sq.push_back(JMP); rq.push_back(1'($urandom_range(0, 1)));
    end
    foreach (sq[i]) step(op, rq[i], sq[i]);
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_outs", 32'(vec), 32'd0);
    @(posedge clk); #3;
    i_rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    logic [5:0] ops [5];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010;

    // Reset held across clock edges, then directed instructions.
    repeat (2) @(posedge clk);
    #2;
    apply_reset();
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 2, 2);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);

    // Ready arrives exactly in the last allowed wait cycle.
    run_instr(6'b000000, 15, 0);
    run_instr(6'b100011, 0, 15);
    run_instr(6'b101011, 1, 15);

    // Fetch timeout: 16 waiting cycles then sticky ERROR.
    for (int i = 0; i < 16; i++) step(6'b000000, 1'b0, F);
    for (int i = 0; i < 4; i++) step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), ERR);
    apply_reset();

    // Memory-read timeout.
    step(6'b100011, 1'b1, F);
    step(6'b100011, 1'b0, DEC);
    step(6'b100011, 1'b0, MADDR);
    for (int i = 0; i < 16; i++) step(6'b100011, 1'b0, MRD);
    step(6'b100011, 1'b1, ERR);
    apply_reset();

    // Asynchronous reset in the middle of a store.
    step(6'b101011, 1'b1, F);
    step(6'b101011, 1'b0, DEC);
    step(6'b101011, 1'b1, MADDR);
    step(6'b101011, 1'b0, MWR);
    step(6'b101011, 1'b0, MWR);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(o_state), 32'd0);
    chk("async_rst_outs", 32'(vec), 32'd0);
    @(posedge clk); #2;
    i_rst_n = 1'b1;
    #1;
    run_instr(6'b000000, 15, 0);

    // Randomized instruction stream with random memory latencies.
    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 5);
      if (k < 5) op = ops[k];
      else begin
        op = 6'($urandom_range(0, 63));
        while (legal(op)) op = 6'($urandom_range(0, 63));
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
